// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-requester (CPU, DMA) arbiter in front of a single-port synchronous RAM.
//   One transaction at a time, fixed four-state sequence:
//     IDLE -> ACCESS -> WAIT -> ACK -> IDLE
//   Request sampled at edge E0, ack high in the cycle after E2, and the block
//   is back in IDLE after E3, for both reads and writes. Ties are broken
//   round-robin: the requester not granted last wins.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   rst        : synchronous active-low reset
//   cpu_req    : CPU request, held until cpu_ack
//   cpu_we     : CPU write (1) / read (0)
//   cpu_addr   : CPU word address (AW bits)
//   cpu_wdata  : CPU write data (DW bits)
//   cpu_rdata  : registered CPU read data
//   cpu_ack    : one-cycle CPU completion pulse
//   dma_*      : same set of signals for the DMA requester
//   ram_addr   : registered RAM address
//   ram_wdata  : registered RAM write data
//   ram_we     : registered RAM write enable (one cycle per write)
//   ram_rdata  : RAM read data, valid one cycle after ram_addr is sampled
//   grant      : current owner, 00 none / 01 CPU / 10 DMA
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    grant
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_ACK    = 2'd3;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_CPU  = 2'b01;
    localparam logic [1:0] GRANT_DMA  = 2'b10;

    // last_grant_r encoding: 0 = CPU was granted last, 1 = DMA was granted last
    localparam logic LAST_CPU = 1'b0;
    localparam logic LAST_DMA = 1'b1;

    logic [1:0]    state_r;
    logic          last_grant_r;
    logic          owner_we_r;

    logic          any_req_s;
    logic          pick_cpu_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    // Arbitration: CPU wins when it is alone or when DMA owned the RAM last.
    always_comb begin
        any_req_s  = cpu_req | dma_req;
        pick_cpu_s = 1'b0;
        if (cpu_req && (!dma_req || (last_grant_r == LAST_DMA))) begin
            pick_cpu_s = 1'b1;
        end else begin
            pick_cpu_s = 1'b0;
        end
    end

    // Mux the winning requester's command onto the capture path.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {AW{1'b0}};
        sel_wdata_s = {DW{1'b0}};
        if (pick_cpu_s) begin
            sel_we_s    = cpu_we;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end else begin
            sel_we_s    = dma_we;
            sel_addr_s  = dma_addr;
            sel_wdata_s = dma_wdata;
        end
    end

    // Transaction sequencer and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= LAST_DMA;
            owner_we_r   <= 1'b0;
            grant        <= GRANT_NONE;
            ram_we       <= 1'b0;
            ram_addr     <= {AW{1'b0}};
            ram_wdata    <= {DW{1'b0}};
            cpu_ack      <= 1'b0;
            dma_ack      <= 1'b0;
            cpu_rdata    <= {DW{1'b0}};
            dma_rdata    <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Command inputs are captured only here, so later changes
                    // on the owner's inputs cannot affect the access.
                    if (any_req_s) begin
                        ram_addr   <= sel_addr_s;
                        ram_wdata  <= sel_wdata_s;
                        ram_we     <= sel_we_s;
                        owner_we_r <= sel_we_s;
                        if (pick_cpu_s) begin
                            grant        <= GRANT_CPU;
                            last_grant_r <= LAST_CPU;
                        end else begin
                            grant        <= GRANT_DMA;
                            last_grant_r <= LAST_DMA;
                        end
                        state_r <= ST_ACCESS;
                    end else begin
                        ram_we  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // RAM samples the command at this edge; write pulse ends.
                    ram_we  <= 1'b0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // ram_rdata now holds the word addressed during ACCESS.
                    if (grant == GRANT_CPU) begin
                        cpu_ack <= 1'b1;
                        if (!owner_we_r) begin
                            cpu_rdata <= ram_rdata;
                        end else begin
                            cpu_rdata <= cpu_rdata;
                        end
                    end else begin
                        dma_ack <= 1'b1;
                        if (!owner_we_r) begin
                            dma_rdata <= ram_rdata;
                        end else begin
                            dma_rdata <= dma_rdata;
                        end
                    end
                    state_r <= ST_ACK;
                end
                ST_ACK: begin
                    // Request levels are ignored here; the owner may still be
                    // dropping its req on this edge.
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    grant   <= GRANT_NONE;
                    state_r <= ST_IDLE;
                end
                default: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    ram_we  <= 1'b0;
                    grant   <= GRANT_NONE;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
